// File: rtl/text_tile_renderer_pkg.sv
// Shared constants and types for the character-cell text renderer.
// Glyph codes 36..63 render as blank.
package text_pkg;

  localparam logic [5:0] CODE_BLANK = 6'd63;
  localparam int GLYPH_W    = 5;
  localparam int GLYPH_H    = 5;
  localparam int CELL_SHIFT = 3;

  typedef enum logic [5:0] {
    CODE_0, CODE_1, CODE_2, CODE_3, CODE_4, CODE_5, CODE_6, CODE_7, CODE_8, CODE_9,
    CODE_A, CODE_B, CODE_C, CODE_D, CODE_E, CODE_F, CODE_G, CODE_H, CODE_I, CODE_J,
    CODE_K, CODE_L, CODE_M, CODE_N, CODE_O, CODE_P, CODE_Q, CODE_R, CODE_S, CODE_T,
    CODE_U, CODE_V, CODE_W, CODE_X, CODE_Y, CODE_Z
  } glyph_code_e;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } fsm_state_e;

  typedef struct packed {
    logic [5:0] code;
    logic [2:0] color;
  } cell_t;

endpackage

// File: rtl/text_tile_renderer_if.sv
// Cell-write handshake bus into the text renderer.
interface text_tile_renderer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [5:0] wr_col;
  logic [5:0] wr_row;
  logic [5:0] wr_code;
  logic [2:0] wr_color;

  modport master (output wr_valid, wr_col, wr_row, wr_code, wr_color, input wr_ready);
  modport slave  (input wr_valid, wr_col, wr_row, wr_code, wr_color, output wr_ready);
endinterface

// File: rtl/text_tile_renderer_glyph_rom.sv
// 5x5 font ROM: one 5-bit row per (code, row); bit 4 is the leftmost pixel.
module glyph_rom_5x5
  import text_pkg::*;
(
  input  logic [5:0] code,
  input  logic [2:0] row,
  output logic [4:0] bits
);

  logic [24:0] glyph;

  always_comb begin
    glyph = '0;
    case (code)
      CODE_0: glyph = 25'b01110_10011_10101_11001_01110;
      CODE_1: glyph = 25'b00100_01100_00100_00100_01110;
      CODE_2: glyph = 25'b01110_10001_00110_01000_11111;
      CODE_3: glyph = 25'b11110_00001_01110_00001_11110;
      CODE_4: glyph = 25'b10010_10010_11111_00010_00010;
      CODE_5: glyph = 25'b11111_10000_11110_00001_11110;
      CODE_6: glyph = 25'b01110_10000_11110_10001_01110;
      CODE_7: glyph = 25'b11111_00010_00100_01000_01000;
      CODE_8: glyph = 25'b01110_10001_01110_10001_01110;
      CODE_9: glyph = 25'b01110_10001_01111_00001_01110;
      CODE_A: glyph = 25'b00100_01010_10001_11111_10001;
      CODE_B: glyph = 25'b11110_10001_11110_10001_11110;
      CODE_C: glyph = 25'b01111_10000_10000_10000_01111;
      CODE_D: glyph = 25'b11110_10001_10001_10001_11110;
      CODE_E: glyph = 25'b11111_10000_11110_10000_11111;
      CODE_F: glyph = 25'b11111_10000_11110_10000_10000;
      CODE_G: glyph = 25'b01111_10000_10011_10001_01110;
      CODE_H: glyph = 25'b10001_10001_11111_10001_10001;
      CODE_I: glyph = 25'b01110_00100_00100_00100_01110;
      CODE_J: glyph = 25'b00011_00001_00001_10001_01110;
      CODE_K: glyph = 25'b10001_10010_11100_10010_10001;
      CODE_L: glyph = 25'b10000_10000_10000_10000_11111;
      CODE_M: glyph = 25'b10001_11011_10101_10001_10001;
      CODE_N: glyph = 25'b10001_11001_10101_10011_10001;
      CODE_O: glyph = 25'b01110_10001_10001_10001_01110;
      CODE_P: glyph = 25'b11110_10001_11110_10000_10000;
      CODE_Q: glyph = 25'b01110_10001_10101_10010_01101;
      CODE_R: glyph = 25'b11110_10001_11110_10010_10001;
      CODE_S: glyph = 25'b01111_10000_01110_00001_11110;
      CODE_T: glyph = 25'b11111_00100_00100_00100_00100;
      CODE_U: glyph = 25'b10001_10001_10001_10001_01110;
      CODE_V: glyph = 25'b10001_10001_10001_01010_00100;
      CODE_W: glyph = 25'b10001_10001_10101_11011_10001;
      CODE_X: glyph = 25'b10001_01010_00100_01010_10001;
      CODE_Y: glyph = 25'b10001_01010_00100_00100_00100;
      CODE_Z: glyph = 25'b11111_00010_00100_01000_11111;
      default: glyph = '0;
    endcase
  end

  // Rows at or beyond GLYPH_H are the inter-glyph gap.
  always_comb begin
    bits = '0;
    if (int'(row) < GLYPH_H) begin
      case (row)
        3'd0:    bits = glyph[24:20];
        3'd1:    bits = glyph[19:15];
        3'd2:    bits = glyph[14:10];
        3'd3:    bits = glyph[9:5];
        3'd4:    bits = glyph[4:0];
        default: bits = '0;
      endcase
    end
  end

endmodule

// File: rtl/text_tile_renderer.sv
// Character-cell text renderer: cell RAM with clear sequencer, blinking cursor,
// and a two-stage pixel pipe from hpos/vpos to rgb.
module text_tile_renderer
  import text_pkg::*;
#(
  parameter int COLS         = 16,
  parameter int ROWS         = 8,
  parameter int SCALE_SHIFT  = 1,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [8:0]           hpos,
  input  logic [8:0]           vpos,
  input  logic                 display_on,
  input  logic                 frame_start,
  input  logic                 clear_req,
  text_tile_renderer_if.slave  wr,
  input  logic                 cursor_en,
  input  logic [5:0]           cursor_col,
  input  logic [5:0]           cursor_row,
  output logic                 busy,
  output logic [2:0]           rgb
);

  localparam int NCELL = COLS * ROWS;
  localparam int AW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  localparam int SH    = CELL_SHIFT + SCALE_SHIFT;
  localparam int BW    = $clog2(BLINK_FRAMES + 1);

  localparam logic [0:0] S_CLEAR = CLEAR;
  localparam logic [0:0] S_IDLE  = IDLE;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  logic          s1_area_q, s1_area_d;
  logic          s1_disp_q, s1_disp_d;
  logic          s1_inv_q, s1_inv_d;
  logic [2:0]    s1_gx_q, s1_gx_d;
  logic [2:0]    s1_gy_q, s1_gy_d;
  cell_t         s1_cell_q, s1_cell_d;
  logic [2:0]    rgb_q, rgb_d;

  cell_t         cell_ram [NCELL];
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  cell_t         ram_wdata;

  logic          wr_fire;
  logic          wr_in_range;
  logic [8:0]    col_full;
  logic [8:0]    row_full;
  logic [AW-1:0] rd_idx;
  logic [4:0]    glyph_bits;
  logic [7:0]    row_ext;
  logic          pix_on;

  assign busy        = (state_q == S_CLEAR);
  // A same-cycle clear request wins over a pending write.
  assign wr.wr_ready = (state_q == S_IDLE) && !clear_req;
  assign wr_fire     = wr.wr_valid && wr.wr_ready;
  assign wr_in_range = (int'(wr.wr_col) < COLS) && (int'(wr.wr_row) < ROWS);
  assign rgb         = rgb_q;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == S_CLEAR) begin
      if (int'(clr_addr_q) == NCELL - 1) begin
        state_d    = S_IDLE;
        clr_addr_d = '0;
      end else begin
        clr_addr_d = clr_addr_q + AW'(1);
      end
    end else if (clear_req) begin
      state_d    = S_CLEAR;
      clr_addr_d = '0;
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (state_q == S_CLEAR) begin
      ram_we    = 1'b1;
      ram_addr  = clr_addr_q;
      ram_wdata = '{code: CODE_BLANK, color: 3'd0};
    end else if (wr_fire && wr_in_range) begin
      ram_we    = 1'b1;
      ram_addr  = AW'(int'(wr.wr_row) * COLS + int'(wr.wr_col));
      ram_wdata = '{code: wr.wr_code, color: wr.wr_color};
    end
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (frame_start) begin
      if (int'(blink_cnt_q) == BLINK_FRAMES - 1) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // Stage 1: cell coordinates, in-cell offsets, cursor hit and RAM read.
  always_comb begin
    col_full  = hpos >> SH;
    row_full  = vpos >> SH;
    s1_area_d = (int'(col_full) < COLS) && (int'(row_full) < ROWS);
    s1_disp_d = display_on;
    s1_gx_d   = hpos[SCALE_SHIFT +: 3];
    s1_gy_d   = vpos[SCALE_SHIFT +: 3];
    s1_inv_d  = cursor_en && phase_q &&
                ({3'b000, cursor_col} == col_full) && ({3'b000, cursor_row} == row_full);
    rd_idx    = s1_area_d ? AW'(int'(row_full) * COLS + int'(col_full)) : '0;
    s1_cell_d = cell_ram[rd_idx];
  end

  glyph_rom_5x5 u_rom (
    .code (s1_cell_q.code),
    .row  (s1_gy_q),
    .bits (glyph_bits)
  );

  // Stage 2: pad the glyph row to 8 so gx 5..7 fall on zeros.
  always_comb begin
    row_ext = {glyph_bits, 3'b000};
    pix_on  = (int'(s1_gx_q) < GLYPH_W) && row_ext[3'd7 - s1_gx_q];
    rgb_d   = '0;
    if (s1_disp_q && s1_area_q) begin
      rgb_d = (pix_on ? s1_cell_q.color : 3'b000) ^ {3{s1_inv_q}};
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) cell_ram[ram_addr] <= ram_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_CLEAR;
      clr_addr_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      s1_area_q   <= 1'b0;
      s1_disp_q   <= 1'b0;
      s1_inv_q    <= 1'b0;
      s1_gx_q     <= '0;
      s1_gy_q     <= '0;
      s1_cell_q   <= '0;
      rgb_q       <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      s1_area_q   <= s1_area_d;
      s1_disp_q   <= s1_disp_d;
      s1_inv_q    <= s1_inv_d;
      s1_gx_q     <= s1_gx_d;
      s1_gy_q     <= s1_gy_d;
      s1_cell_q   <= s1_cell_d;
      rgb_q       <= rgb_d;
    end
  end

endmodule
